mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single external instruction/data memory between the instruction-cache refill path (I-port, read-only) and the data-side port (D-port, read/write). It sits between the caches and the memory model. It serializes accesses, holds each granted access for a fixed memory latency, and returns read data with a one-cycle done pulse. Grant policy is fixed-priority or round-robin, selected at compile time.

## Interface
- MEM_LATENCY, 2: cycles `mem_en` is held per access before `mem_rdata` is sampled; legal range ≥1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  I-port request; held high until `i_done`.
- i_addr  in  32  I-port byte address.
- i_rdata  out  32  I-port read data, valid while `i_done`=1, then held.
- i_done  out  1  one-cycle completion pulse, I-port.
- d_req  in  1  D-port request; held high until `d_done`.
- d_we  in  1  D-port write enable.
- d_addr  in  32  D-port byte address.
- d_wdata  in  32  D-port write data.
- d_rdata  out  32  D-port read data, valid while `d_done`=1, then held.
- d_done  out  1  one-cycle completion pulse, D-port.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address; `[1:0]` forced to 0.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- grant  out  2  one-hot owner of the current access: `[0]`=I, `[1]`=D.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - **IDLE**: if any request is high, pick a winner, latch its addr/we/wdata, set `grant`, load counter = MEM_LATENCY, and go to ACCESS. Otherwise stay in IDLE.
  - **ACCESS**: `mem_en`=1 with the latched signals; decrement the counter each cycle. When the counter reaches 1, sample `mem_rdata` into the winner's rdata register (reads only) and go to DONE.
  - **DONE**: pulse the winner's done; clear `grant`; go to IDLE.
- Writes pulse done but leave that port's rdata register unchanged.
- A request dropped during ACCESS is ignored: the access completes and done still pulses.
- Requesters drop req at the clock edge that ends the DONE cycle, so IDLE never re-grants a finished request.
- Counter width is $clog2(MEM_LATENCY+1). No wrap is possible: the counter is loaded only in IDLE.
- Simultaneous requests in IDLE are resolved per Configuration. A request arriving while ACCESS or DONE is in progress waits; there is no preemption.

## Timing
- Reset values: state=IDLE, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `grant`=0, `i_done`=`d_done`=0, `i_rdata`=`d_rdata`=0, round-robin pointer=I.
- Reset mid-access: outputs drop immediately (async). The aborted access produces no done pulse.
- All outputs are registered. If req is sampled high at edge N:
  - `mem_en` is high during cycles N+1 … N+MEM_LATENCY.
  - done is high in cycle N+MEM_LATENCY+1.
  - The next grant edge is at the end of the following IDLE cycle.
- Throughput: one access per MEM_LATENCY+2 cycles.
- `mem_rdata` is sampled at the edge ending the last ACCESS cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the port not granted last. The pointer updates on every grant.
- ARB_ROUND_ROBIN_EN undefined: D always wins ties (fixed priority). No pointer is kept.

## Structure
- Shared package `mem_arb_pkg`: FSM state encoding, grant bit indices (GNT_I=0, GNT_D=1), default MEM_LATENCY.
- One sub-module, `arb_pick`: combinational 2-way pick from req[1:0] and last_grant. The round-robin or fixed-priority variant is chosen by the macro.

## Test plan
- I-only read, MEM_LATENCY=2, i_addr=0x0000_0013, mem_rdata=0xDEAD_BEEF → `mem_addr`=0x10; `mem_en` high for 2 cycles; `i_done` pulses 3 cycles after the grant edge; `i_rdata`=0xDEAD_BEEF.
- D write, d_addr=0x40, d_wdata=0x1234_5678 → `mem_we`=1 and `mem_wdata`=0x1234_5678 during ACCESS; `d_done` pulses; `d_rdata` unchanged.
- Simultaneous i_req and d_req, three back-to-back rounds:
  - without macro: grants D, I, D… as D re-requests after each of its grants;
  - with ARB_ROUND_ROBIN_EN: first grant is D, then alternating I, D.
- d_req rises during an I access → D waits; D is granted exactly one IDLE cycle after `i_done`; no overlapping `mem_en`.
- Assert rst in the second ACCESS cycle → `mem_en`=0 immediately; no done pulse; a new i_req after reset completes normally.
- MEM_LATENCY=1 → `mem_en` high for 1 cycle; done pulses 2 cycles after the grant edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding, grant indices and default latency for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  localparam int MEM_LATENCY_DEF = 2;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational 2-way pick; round-robin under ARB_ROUND_ROBIN_EN, else D wins ties
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last_d,
`endif
  input  logic [1:0] req,
  output logic [1:0] pick
);

  always_comb begin
    pick = '0;
    if (req[GNT_I] && req[GNT_D]) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_d) pick[GNT_I] = 1'b1;
      else        pick[GNT_D] = 1'b1;
`else
      pick[GNT_D] = 1'b1;
`endif
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D port arbiter for one shared memory with fixed access latency
// Optional round-robin tie-break: define ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    pick;
  // Owner of the current/last access; doubles as the round-robin pointer (0 = I).
  logic          last_d;

  arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .last_d (last_d),
`endif
    .req    ({d_req, i_req}),
    .pick   (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pick) state_nx = ACCESS;
      ACCESS:  if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      last_d    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|pick) begin
            mem_en <= 1'b1;
            grant  <= pick;
            last_d <= pick[GNT_D];
            cnt    <= CW'(MEM_LATENCY);
            if (pick[GNT_D]) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr & 32'hFFFF_FFFC;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr & 32'hFFFF_FFFC;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Last access cycle: capture read data and raise done for the DONE cycle.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            grant  <= '0;
            if (last_d) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (optionally with ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, d_we, i_done, d_done, mem_en, mem_we;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  logic        q_i_req, q_d_req, q_d_we, q_i_done, q_d_done, q_mem_en, q_mem_we;
  logic [31:0] q_i_addr, q_d_addr, q_d_wdata, q_i_rdata, q_d_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;
  logic [1:0]  q_grant;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(q_i_req), .i_addr(q_i_addr), .i_rdata(q_i_rdata), .i_done(q_i_done),
    .d_req(q_d_req), .d_we(q_d_we), .d_addr(q_d_addr), .d_wdata(q_d_wdata),
    .d_rdata(q_d_rdata), .d_done(q_d_done),
    .mem_en(q_mem_en), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
    .mem_rdata(q_mem_rdata), .grant(q_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input string tag, output logic [1:0] g);
    g = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_en) begin
        g = grant;
        return;
      end
    end
    check({tag, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, input bit is_d, output int k);
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (is_d ? d_done : i_done) return;
    end
    check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // One isolated access from IDLE on the L=2 instance.
  task automatic single(input string tag, input bit is_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input logic [31:0] exp_addr,
                        input logic [31:0] exp_rdata);
    int en_cnt, dk;
    logic [31:0] a_seen, w_seen;
    logic we_seen;
    logic [1:0] g_seen;
    en_cnt = 0; dk = 0; a_seen = '0; w_seen = '0; we_seen = 1'b0; g_seen = '0;
    mem_rdata = mrd;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (en_cnt == 0) begin
          a_seen = mem_addr; w_seen = mem_wdata; we_seen = mem_we; g_seen = grant;
        end
        en_cnt++;
      end
      if (is_d ? d_done : i_done) begin
        dk = k;
        break;
      end
    end
    check({tag, "_done_cycle"}, dk, 3);
    check({tag, "_en_cycles"}, en_cnt, 2);
    check({tag, "_addr"}, a_seen, exp_addr);
    check({tag, "_we"}, we_seen, we);
    check({tag, "_grant"}, g_seen, is_d ? 2'b10 : 2'b01);
    if (we) check({tag, "_wdata"}, w_seen, wdata);
    check({tag, "_rdata"}, is_d ? d_rdata : i_rdata, exp_rdata);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, {i_done, d_done}, 2'b00);
  endtask

  logic [1:0] g;
  int         dk, cnt, bad;

  initial begin
    rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    q_i_req = 0; q_d_req = 0; q_d_we = 0; q_i_addr = 0; q_d_addr = 0; q_d_wdata = 0; q_mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {mem_en, mem_we, grant, i_done, d_done}, 6'd0);
    check("rst_addr", mem_addr | mem_wdata, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_en", mem_en, 1'b0);

    single("i_read", 1'b0, 1'b0, 32'h0000_0013, 32'd0, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF);
    single("d_write", 1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'hCAFE_F00D, 32'h40, 32'd0);
    single("d_read", 1'b1, 1'b0, 32'h0000_0086, 32'd0, 32'h0BAD_F00D, 32'h84, 32'h0BAD_F00D);

    // Tie rounds from a fresh pointer.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    i_addr = 32'h100; d_addr = 32'h200; d_we = 0;
    i_req = 1; d_req = 1;
    wait_grant("tie1", g);  check("tie1_gnt", g, 2'b10);
    wait_done("tie1", 1'b1, dk); d_req = 0;
    wait_grant("tie2", g);  check("tie2_gnt", g, 2'b01);
    d_req = 1;
    wait_done("tie2", 1'b0, dk); i_req = 0;
    wait_grant("tie3", g);  check("tie3_gnt", g, 2'b10);
    i_req = 1;
    wait_done("tie3", 1'b1, dk); d_req = 0;
    @(negedge clk); d_req = 1;
    wait_grant("tie4", g);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie4_gnt", g, 2'b01);
`else
    check("tie4_gnt", g, 2'b10);
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_done) i_req = 0;
      if (d_done) d_req = 0;
    end
    check("tie_drained", {i_req, d_req, mem_en}, 3'd0);

    // D arrives during an I access.
    i_req = 1; i_addr = 32'h300;
    wait_grant("wait_i", g); check("wait_i_gnt", g, 2'b01);
    d_req = 1; d_addr = 32'h400;
    wait_done("wait_i", 1'b0, dk); i_req = 0;
    check("wait_no_overlap", mem_en, 1'b0);
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_en) begin cnt = k; break; end
    end
    check("wait_d_gap", cnt, 2);
    check("wait_d_gnt", grant, 2'b10);
    wait_done("wait_d", 1'b1, dk); d_req = 0;
    @(negedge clk);

    // Reset in the second ACCESS cycle.
    i_req = 1; i_addr = 32'h500;
    wait_grant("rstmid", g);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_en", {mem_en, grant}, 3'd0);
    i_req = 0;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (i_done || d_done || mem_en) bad++;
    end
    check("rstmid_no_done", bad, 0);
    single("after_rst", 1'b0, 1'b0, 32'h0000_0507, 32'd0, 32'h7777_1111, 32'h504, 32'h7777_1111);

    // Latency 1 instance.
    q_mem_rdata = 32'hA5A5_0001; q_i_addr = 32'h22; q_i_req = 1;
    cnt = 0; dk = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (q_mem_en) cnt++;
      if (q_i_done) begin dk = k; break; end
    end
    q_i_req = 0;
    check("lat1_done_cycle", dk, 2);
    check("lat1_en_cycles", cnt, 1);
    check("lat1_rdata", q_i_rdata, 32'hA5A5_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
